// File: rtl/nibble_packer_pkg.sv
// Shared types for the nibble packer: the packed nibble pair, the
// assembly FSM state encoding and a small pair-building helper.
package nibble_packer_pkg;

  // The first nibble of a pair (lo) occupies the upper half of the byte,
  // so {lo, hi} reads left-to-right in arrival order: 5 then a -> 8'h5a.
  typedef struct packed {
    bit [3:0] lo;
    bit [3:0] hi;
  } nib_pair_t;

  // Assembly FSM: waiting for the first (lo) or the second (hi) nibble.
  typedef enum logic [0:0] {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } pack_state_e;

  // Build a packed pair from the stored lo nibble and the arriving hi nibble.
  function automatic nib_pair_t make_pair(input logic [3:0] lo,
                                          input logic [3:0] hi);
    nib_pair_t p;
    p.lo = lo;
    p.hi = hi;
    return p;
  endfunction

endpackage : nibble_packer_pkg

// File: rtl/nibble_packer_out_reg.sv
// One-entry valid/ready holding register for packed bytes. A new byte may
// be loaded whenever the slot is empty or is being emptied this cycle, so a
// delivery and a load in the same cycle keep the stream running at full rate.
module nibble_out_reg
  import nibble_packer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  nib_pair_t load_data_i,
  output logic      can_load_o,
  input  logic      out_ready_i,
  output logic      out_valid_o,
  output nib_pair_t out_data_o,
  output logic      deliver_o
);

  logic      valid_q, valid_d;
  nib_pair_t data_q, data_d;

  assign deliver_o   = valid_q && out_ready_i;
  assign can_load_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next-state: a load wins over a delivery; otherwise a delivery empties the slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (deliver_o) begin
      valid_d = 1'b0;
    end
  end

  // Register the slot; data is held untouched while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too, because out_data must read 8'h00
      // out of reset rather than whatever the flops power up with.
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : nibble_out_reg

// File: rtl/nibble_packer.sv
// Nibble packer: assembles pairs of 4-bit nibbles into bytes {lo, hi},
// presents them through a one-entry output register with valid/ready
// handshaking and counts delivered bytes. flush drops a half-built pair.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             partial,
  output logic [CNT_W-1:0] byte_count
);

  pack_state_e      state_q, state_d;
  logic [3:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic      accept;
  logic      load;
  logic      can_load;
  logic      deliver;
  nib_pair_t out_pair;

  // in_ready looks only at state, flush and output-slot occupancy, never at
  // in_valid, so the producer can wait on it without a combinational loop.
  assign in_ready = !flush && ((state_q == WAIT_LO) || can_load);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (state_q == WAIT_HI);

  assign partial    = (state_q == WAIT_HI);
  assign out_data   = out_pair;
  assign byte_count = cnt_q;

  nibble_out_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (make_pair(lo_q, in_data)),
    .can_load_o  (can_load),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_pair),
    .deliver_o   (deliver)
  );

  // Assembly FSM and lo storage; flush overrides any accepted nibble.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = WAIT_LO;
      lo_d    = 4'h0;
    end else if (accept) begin
      if (state_q == WAIT_LO) begin
        lo_d    = in_data;
        state_d = WAIT_HI;
      end else begin
        state_d = WAIT_LO;
      end
    end
  end

  // Delivered-byte counter; wraps silently and ignores flush.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, stored lo nibble and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LO;
      lo_q    <= 4'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : nibble_packer
